// File: rtl/bsg_chip_swizzle_adapter_prog.sv
// Runtime-programmable lane swizzle between pads and guts. A shadow map is written
// over a config port, scanned for being a legal per-channel permutation, then committed.
module bsg_chip_swizzle_adapter_prog #(
  parameter  int channels_p     = 4,
  parameter  int width_p        = 10,
  localparam int lg_width_lp    = $clog2(width_p),
  localparam int lg_channels_lp = (channels_p > 1) ? $clog2(channels_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cfg_v_i,
  input  logic [lg_channels_lp-1:0]     cfg_chan_i,
  input  logic [lg_width_lp-1:0]        cfg_lane_i,
  input  logic [lg_width_lp-1:0]        cfg_sel_i,
  input  logic                          cfg_commit_i,
  output logic                          cfg_ready_o,
  output logic                          done_o,
  output logic                          err_o,
  input  logic [channels_p-1:0]         port_clk_i,
  input  logic [channels_p*width_p-1:0] port_lanes_i,
  output logic [channels_p-1:0]         port_tkn_o,
  output logic [channels_p-1:0]         guts_clk_o,
  output logic [channels_p*width_p-1:0] guts_lanes_o,
  input  logic [channels_p-1:0]         guts_tkn_i
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_e;
  typedef logic [lg_width_lp-1:0] sel_t;

  localparam int sel_span_lp = 1 << lg_width_lp;
  localparam sel_t last_lane_lp = sel_t'(width_p - 1);
  localparam logic [lg_channels_lp-1:0] last_chan_lp = lg_channels_lp'(channels_p - 1);

  state_e state_r, state_n;
  sel_t   act_r [channels_p][width_p];
  sel_t   shd_r [channels_p][width_p];

  logic [lg_channels_lp-1:0] scan_chan_r;
  sel_t                      scan_lane_r;
  logic [sel_span_lp-1:0]    used_r;
  logic                      err_acc_r;
  logic                      done_r;
  logic                      err_r;

  sel_t scan_sel;
  logic scan_last;
  logic entry_err;

  // Link path: clocks and tokens pass straight through, lanes are pure muxes.
  assign guts_clk_o = port_clk_i;
  assign port_tkn_o = guts_tkn_i;

  for (genvar c = 0; c < channels_p; c++) begin : g_chan
    logic [width_p-1:0] chan_lanes;
    assign chan_lanes = port_lanes_i[c*width_p +: width_p];
    for (genvar l = 0; l < width_p; l++) begin : g_lane
      assign guts_lanes_o[c*width_p + l] = chan_lanes[act_r[c][l]];
    end
  end

  assign cfg_ready_o = (state_r == IDLE);
  assign done_o      = done_r;
  assign err_o       = err_r;

  // used_r spans every encodable select so an illegal select never indexes out of range.
  assign scan_sel  = shd_r[scan_chan_r][scan_lane_r];
  assign scan_last = (scan_chan_r == last_chan_lp) && (scan_lane_r == last_lane_lp);
  assign entry_err = (scan_sel > last_lane_lp) || used_r[scan_sel];

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (cfg_commit_i) state_n = CHECK;
      CHECK:   if (scan_last) state_n = (err_acc_r || entry_err) ? IDLE : APPLY;
      APPLY:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_acc_r   <= 1'b0;
      used_r      <= '0;
      scan_chan_r <= '0;
      scan_lane_r <= '0;
      // NOTE: the maps are flop arrays, not RAM, so resetting them to identity is legal and cheap.
      for (int c = 0; c < channels_p; c++) begin
        for (int l = 0; l < width_p; l++) begin
          act_r[c][l] <= sel_t'(l);
          shd_r[c][l] <= sel_t'(l);
        end
      end
    end else begin
      state_r <= state_n;
      done_r  <= (state_r == APPLY);
      unique case (state_r)
        IDLE: begin
          // Write before commit: a same-cycle commit scans the freshly written entry.
          if (cfg_v_i) begin
            for (int c = 0; c < channels_p; c++) begin
              for (int l = 0; l < width_p; l++) begin
                if (cfg_chan_i == lg_channels_lp'(c) && cfg_lane_i == sel_t'(l))
                  shd_r[c][l] <= cfg_sel_i;
              end
            end
          end
          if (cfg_commit_i) begin
            err_r       <= 1'b0;
            err_acc_r   <= 1'b0;
            used_r      <= '0;
            scan_chan_r <= '0;
            scan_lane_r <= '0;
          end
        end
        CHECK: begin
          err_acc_r <= err_acc_r || entry_err;
          if (scan_lane_r == last_lane_lp) begin
            used_r      <= '0;
            scan_lane_r <= '0;
            scan_chan_r <= scan_chan_r + 1'b1;
          end else begin
            if (!entry_err) used_r[scan_sel] <= 1'b1;
            scan_lane_r <= scan_lane_r + 1'b1;
          end
          if (scan_last && (err_acc_r || entry_err)) err_r <= 1'b1;
        end
        APPLY:   act_r <= shd_r;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_chip_swizzle_adapter_prog.sv
// Directed bench for the programmable swizzle: vector tables for the link path,
// hand-written sequences for commit timing, rejection, busy drops and mid-scan reset.
module tb_bsg_chip_swizzle_adapter_prog;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cfg_v_i;
  logic [1:0]  cfg_chan_i;
  logic [3:0]  cfg_lane_i;
  logic [3:0]  cfg_sel_i;
  logic        cfg_commit_i;
  logic        cfg_ready_o;
  logic        done_o;
  logic        err_o;
  logic [3:0]  port_clk_i;
  logic [39:0] port_lanes_i;
  logic [3:0]  port_tkn_o;
  logic [3:0]  guts_clk_o;
  logic [39:0] guts_lanes_o;
  logic [3:0]  guts_tkn_i;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [39:0] lanes_in;
    logic [39:0] lanes_exp;
    logic [3:0]  clk_in;
    logic [3:0]  tkn_in;
  } vec_t;

  vec_t id_vecs  [6];
  vec_t rev_vecs [6];

  bsg_chip_swizzle_adapter_prog dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_chan_i   (cfg_chan_i),
    .cfg_lane_i   (cfg_lane_i),
    .cfg_sel_i    (cfg_sel_i),
    .cfg_commit_i (cfg_commit_i),
    .cfg_ready_o  (cfg_ready_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .port_clk_i   (port_clk_i),
    .port_lanes_i (port_lanes_i),
    .port_tkn_o   (port_tkn_o),
    .guts_clk_o   (guts_clk_o),
    .guts_lanes_o (guts_lanes_o),
    .guts_tkn_i   (guts_tkn_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ticks(input int n, output logic saw_done);
    saw_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done_o === 1'b1) saw_done = 1'b1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [3:0] l, input logic [3:0] s);
    cfg_v_i    = 1'b1;
    cfg_chan_i = c;
    cfg_lane_i = l;
    cfg_sel_i  = s;
    tick();
    cfg_v_i = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit_i = 1'b1;
    tick();
    cfg_commit_i = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    port_lanes_i = v.lanes_in;
    port_clk_i   = v.clk_in;
    guts_tkn_i   = v.tkn_in;
    #1;
    check({tag, " lanes"}, 64'(guts_lanes_o), 64'(v.lanes_exp));
    check({tag, " clk"},   64'(guts_clk_o),   64'(v.clk_in));
    check({tag, " tkn"},   64'(port_tkn_o),   64'(v.tkn_in));
  endtask

  task automatic lane_check(input string name, input logic [39:0] in, input logic [39:0] exp);
    port_lanes_i = in;
    #1;
    check(name, 64'(guts_lanes_o), 64'(exp));
  endtask

  initial begin
    logic saw_done;
    logic [39:0] w;

    id_vecs[0] = '{40'h00_0000_0000, 40'h00_0000_0000, 4'h0, 4'hF};
    id_vecs[1] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 4'hF, 4'h0};
    id_vecs[2] = '{40'h00_0000_0001, 40'h00_0000_0001, 4'h5, 4'hA};
    id_vecs[3] = '{40'h80_0000_0000, 40'h80_0000_0000, 4'hA, 4'h5};
    id_vecs[4] = '{40'h00_0010_0000, 40'h00_0010_0000, 4'h1, 4'h8};
    id_vecs[5] = '{40'hAA_AAAA_AAAA, 40'hAA_AAAA_AAAA, 4'h6, 4'h3};

    // Channel 2 (bits 20..29) reversed, everything else identity.
    rev_vecs[0] = '{40'h00_0010_0000, 40'h00_2000_0000, 4'h3, 4'hC};
    rev_vecs[1] = '{40'h00_0040_0000, 40'h00_0800_0000, 4'h9, 4'h6};
    rev_vecs[2] = '{40'h00_3050_0000, 40'h00_2830_0000, 4'h0, 4'h1};
    rev_vecs[3] = '{40'hFF_C010_03FF, 40'hFF_E000_03FF, 4'h7, 4'hE};
    rev_vecs[4] = '{40'hAA_AAAA_AAAA, 40'hAA_955A_AAAA, 4'hC, 4'h2};
    rev_vecs[5] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 4'hF, 4'hF};

    reset_n_i    = 1'b0;
    cfg_v_i      = 1'b0;
    cfg_chan_i   = '0;
    cfg_lane_i   = '0;
    cfg_sel_i    = '0;
    cfg_commit_i = 1'b0;
    port_clk_i   = '0;
    port_lanes_i = '0;
    guts_tkn_i   = '0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();

    // Reset state and identity link path.
    check("reset ready", 64'(cfg_ready_o), 64'(1));
    check("reset done",  64'(done_o),      64'(0));
    check("reset err",   64'(err_o),       64'(0));
    for (int i = 0; i < 6; i++) apply_vec(id_vecs[i], "ident");
    for (int i = 0; i < 40; i++) begin
      w = 40'd1 << i;
      lane_check("walk", w, w);
    end

    // Reverse channel 2 and commit; done exactly at E0+41.
    for (int l = 0; l < 10; l++) cfg_write(2'd2, 4'(l), 4'(9 - l));
    lane_check("shadow only", 40'h00_0010_0000, 40'h00_0010_0000);
    do_commit();
    check("busy ready", 64'(cfg_ready_o), 64'(0));
    wait_ticks(40, saw_done);
    check("rev early done", 64'(saw_done), 64'(0));
    check("rev apply ready", 64'(cfg_ready_o), 64'(0));
    lane_check("rev pre-apply", 40'h00_0010_0000, 40'h00_0010_0000);
    tick();
    check("rev done", 64'(done_o), 64'(1));
    check("rev ready", 64'(cfg_ready_o), 64'(1));
    check("rev err", 64'(err_o), 64'(0));
    tick();
    check("rev done pulse", 64'(done_o), 64'(0));
    for (int i = 0; i < 6; i++) apply_vec(rev_vecs[i], "rev");

    // Duplicate select on channel 0 is rejected at E0+40.
    cfg_write(2'd0, 4'd0, 4'd3);
    cfg_write(2'd0, 4'd1, 4'd3);
    do_commit();
    wait_ticks(39, saw_done);
    check("dup err early", 64'(err_o), 64'(0));
    check("dup busy", 64'(cfg_ready_o), 64'(0));
    tick();
    check("dup err", 64'(err_o), 64'(1));
    check("dup ready", 64'(cfg_ready_o), 64'(1));
    check("dup done", 64'(done_o | saw_done), 64'(0));
    lane_check("dup act kept", 40'h00_0000_0008, 40'h00_0000_0008);
    wait_ticks(3, saw_done);
    check("dup err sticky", 64'(err_o), 64'(1));
    check("dup no done", 64'(saw_done), 64'(0));

    // Repair as a swap of lanes 0 and 1 and recommit.
    cfg_write(2'd0, 4'd0, 4'd1);
    cfg_write(2'd0, 4'd1, 4'd0);
    check("err held over write", 64'(err_o), 64'(1));
    do_commit();
    check("err cleared", 64'(err_o), 64'(0));
    wait_ticks(40, saw_done);
    check("fix early done", 64'(saw_done), 64'(0));
    tick();
    check("fix done", 64'(done_o), 64'(1));
    check("fix err", 64'(err_o), 64'(0));
    lane_check("swap lane0", 40'h00_0000_0001, 40'h00_0000_0002);
    lane_check("swap lane1", 40'h00_0000_0002, 40'h00_0000_0001);
    apply_vec(rev_vecs[2], "rev kept");

    // Out-of-range select is rejected the same way.
    cfg_write(2'd1, 4'd4, 4'd12);
    do_commit();
    wait_ticks(39, saw_done);
    check("range err early", 64'(err_o), 64'(0));
    tick();
    check("range err", 64'(err_o), 64'(1));
    check("range done", 64'(done_o | saw_done), 64'(0));
    lane_check("range act kept", 40'h00_0000_4000, 40'h00_0000_4000);
    cfg_write(2'd1, 4'd4, 4'd4);

    // Write and commit during CHECK are dropped; shadow stays legal.
    do_commit();
    wait_ticks(5, saw_done);
    cfg_v_i      = 1'b1;
    cfg_chan_i   = 2'd1;
    cfg_lane_i   = 4'd4;
    cfg_sel_i    = 4'd12;
    cfg_commit_i = 1'b1;
    tick();
    cfg_v_i      = 1'b0;
    cfg_commit_i = 1'b0;
    if (done_o === 1'b1) saw_done = 1'b1;
    begin
      logic saw2;
      wait_ticks(34, saw2);
      check("busy early done", 64'(saw_done | saw2), 64'(0));
    end
    tick();
    check("busy done", 64'(done_o), 64'(1));
    check("busy err", 64'(err_o), 64'(0));
    lane_check("busy ch1 lane4", 40'h00_0000_4000, 40'h00_0000_4000);
    tick();
    check("busy no restart", 64'(cfg_ready_o), 64'(1));

    // Reset at E0+20 during CHECK aborts and restores identity.
    do_commit();
    wait_ticks(19, saw_done);
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    check("rst ready", 64'(cfg_ready_o), 64'(1));
    check("rst done", 64'(done_o), 64'(0));
    check("rst err", 64'(err_o), 64'(0));
    wait_ticks(30, saw_done);
    check("rst no done", 64'(saw_done), 64'(0));
    check("rst no err", 64'(err_o), 64'(0));
    lane_check("rst ident ch0", 40'h00_0000_0001, 40'h00_0000_0001);
    apply_vec(id_vecs[5], "rst ident");

    // Shadow was also restored: a bare commit applies identity cleanly.
    do_commit();
    wait_ticks(40, saw_done);
    tick();
    check("rst recommit done", 64'(done_o), 64'(1));
    check("rst recommit err", 64'(err_o), 64'(0));
    apply_vec(id_vecs[4], "rst shadow ident");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_chip_swizzle_adapter_prog.md
# bsg_chip_swizzle_adapter_prog

Programmable successor to the fixed comm-link swizzle adapter: routes `channels_p` source-synchronous channels of `width_p` lanes each from the port side to the guts side. Each lane gets its own runtime-configured source lane, so one chip netlist serves several package and board pinouts. A shadow table is written over a config port, checked for being a legal permutation by a scan FSM, then committed atomically to the active table. The block sits in toplevel `bsg_chip`, between pads and `bsg_chip_guts`.

## Interface
Parameters:
- `channels_p`, 4, number of channels.
- `width_p`, 10, lanes per channel (valid + 9 data, treated uniformly).
- `lg_width_lp`, `$clog2(width_p)`, derived; not overridable.
- `lg_channels_lp`, `max(1, $clog2(channels_p))`, derived; not overridable.

Ports:
- `clk_i`  in  1  core/config clock; the only clock.
- `reset_n_i`  in  1  synchronous, active-low reset.
- `cfg_v_i`  in  1  shadow write strobe.
- `cfg_chan_i`  in  `lg_channels_lp`  target channel.
- `cfg_lane_i`  in  `lg_width_lp`  target output lane.
- `cfg_sel_i`  in  `lg_width_lp`  source lane within the same channel.
- `cfg_commit_i`  in  1  request check and apply of the shadow table.
- `cfg_ready_o`  out  1  high in IDLE; writes and commits are accepted only when high.
- `done_o`  out  1  one-cycle pulse: new active table now in force.
- `err_o`  out  1  sticky: last commit was rejected.
- `port_clk_i`  in  `channels_p`  per-channel link clocks.
- `port_lanes_i`  in  `channels_p*width_p`  lanes; channel c occupies `[c*width_p +: width_p]`.
- `port_tkn_o`  out  `channels_p`  tokens back to the pads.
- `guts_clk_o`  out  `channels_p`  link clocks toward guts.
- `guts_lanes_o`  out  `channels_p*width_p`  swizzled lanes.
- `guts_tkn_i`  in  `channels_p`  tokens from guts.

## Operation
- Datapath is purely combinational from the active table. Link signals never cross a clk_i flop.
  - `guts_lanes_o[c*width_p+l] = port_lanes_i[c*width_p + act[c][l]]`
  - `guts_clk_o = port_clk_i`
  - `port_tkn_o = guts_tkn_i`
- Tables `act` and `shd` hold `channels_p*width_p` entries of `lg_width_lp` bits.
- Write: in IDLE with `cfg_v_i=1`, `shd[cfg_chan_i][cfg_lane_i] <= cfg_sel_i`.
  - An out-of-range `cfg_chan_i` is ignored.
  - `cfg_v_i` and `cfg_commit_i` in the same IDLE cycle: the write lands first, then the commit is taken, so the scan sees the new entry.
- FSM states: IDLE, CHECK, APPLY.
  - IDLE -> CHECK on `cfg_commit_i`. Clears `err_o`, the scan counter, the error accumulator and the used-vector.
  - CHECK visits one entry per cycle, in channel-major, lane-minor order. An entry is in error if `sel >= width_p` or the used-vector bit for `sel` is already set; otherwise the bit is set. The used-vector clears at each channel boundary.
  - CHECK -> APPLY after the last entry with no error. CHECK -> IDLE with `err_o <= 1` if any entry erred. On rejection, `act` is unchanged.
  - APPLY: `act <= shd` in one edge, then IDLE with `done_o=1` for that cycle.
- Commits, and writes while busy, are dropped with no queuing. `err_o` holds until the next accepted commit or reset.

## Timing
- N = `channels_p*width_p`. The commit is sampled at edge E0.
- CHECK spans edges E0+1 .. E0+N.
  - Success: state is APPLY after E0+N. `act` updates at E0+N+1; `done_o` is high and `cfg_ready_o` is high from E0+N+1.
  - Failure: IDLE and `err_o=1` from E0+N.
- Write-to-shadow latency is one edge. The link path has zero cycles, combinational only.
- Reset (`reset_n_i=0` at an edge) values:
  - `act` and `shd` load identity (`sel = l`).
  - State IDLE; `done_o=0`, `err_o=0`, `cfg_ready_o=1` after the reset edge.
  - Reset during CHECK or APPLY aborts the commit and restores identity.
- `act` changes only at an APPLY edge. The system must quiesce links around a commit; the block provides no glitch protection.

## Test plan
- Reset, then drive `port_lanes_i` with a walking one -> `guts_lanes_o` equals `port_lanes_i`; `cfg_ready_o=1`, `done_o=0`, `err_o=0`.
- Write a reversal (`sel = 9-l`) on channel 2 and commit at E0 -> `done_o` pulses at E0+41 (defaults). Channel 2 output lane 0 then follows input lane 9; other channels stay identity.
- Write duplicate `sel=3` on lanes 0 and 1 of channel 0, then commit -> `err_o=1` at E0+40, `done_o` stays 0, `act` unchanged. A correct rewrite plus recommit clears `err_o` and applies.
- Write `sel=12` (>= `width_p`) -> rejected, the same as a duplicate.
- Issue `cfg_v_i` and `cfg_commit_i` during CHECK -> both ignored; `shd` keeps its pre-commit contents, confirmed by the next commit's result.
- Assert reset at E0+20 mid-CHECK -> identity map, IDLE, no `done_o` or `err_o` afterward.
